// File: rtl/debounce_fsm.sv
// Switch debouncer: two-flop synchroniser feeding a 4-state Moore FSM that
// only accepts a new level after it has been stable for STABLE_CYCLES clocks.
module debounce_fsm #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db_level,
  output logic busy
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_level_q, db_level_d;
  logic             busy_q, busy_d;

  // State register; outputs are flopped from the next-state decode so they
  // track the state register exactly while staying glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= ZERO;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_q <= db_level_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and counter logic; any abort restarts qualification at zero.
  always_comb begin
    s1_d    = sw;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ZERO: begin
        if (s2_q) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!s2_q) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ONE: begin
        if (!s2_q) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (s2_q) begin
          state_d = ONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
    db_level_d = (state_d == ONE) || (state_d == WAIT0);
    busy_d     = (state_d == WAIT1) || (state_d == WAIT0);
  end

  assign db_level = db_level_q;
  assign busy     = busy_q;

endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
- Conditions a raw mechanical switch/button input into a clean, glitch-free level.
- Sits directly upstream of the rising-edge detector; its db_level output drives that block's level input.
- Stages: two-flop synchroniser, then a 4-state Moore FSM with a stability counter.
- A new output value is accepted only after the synchronised input has held constant for STABLE_CYCLES consecutive clocks.

Parameters:
- STABLE_CYCLES, 4, number of consecutive clocks the synchronised input must hold a new value before db_level changes. Legal range is 1 to 2^CNT_W-1; hardware builds override it, e.g. 1_000_000 at 100 MHz.
- CNT_W, 8, width of the stability counter in bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- sw  input  1  raw asynchronous switch input, may bounce or glitch.
- db_level  output  1  debounced level; feeds the downstream edge detector.
- busy  output  1  high while a candidate transition is being qualified (states WAIT1/WAIT0).

Behaviour:
- One clock domain.
- Reset is asynchronous, active-low. While rst=0:
  - sync flops s1 and s2 = 0
  - state = ZERO
  - cnt = 0
  - db_level = 0, busy = 0
- Reset assertion mid-operation forces these values immediately, without waiting for a clock edge.
- Synchroniser: s1 <= sw, s2 <= s1 on every clock. The FSM sees only s2.
- States (2-bit encoding): ZERO=00, WAIT1=01, ONE=10, WAIT0=11.
- Moore outputs, decoded from the state register only:
  - db_level = 1 in ONE and WAIT0, else 0.
  - busy = 1 in WAIT1 and WAIT0, else 0.
- Transitions, evaluated each rising clk edge:
  - ZERO: s2=1 -> WAIT1 with cnt<=0; else stay in ZERO.
  - WAIT1: s2=0 -> ZERO (abort, cnt<=0). s2=1 and cnt==STABLE_CYCLES-1 -> ONE (cnt<=0). s2=1 otherwise -> stay, cnt<=cnt+1.
  - ONE: s2=0 -> WAIT0 with cnt<=0; else stay in ONE.
  - WAIT0: s2=1 -> ONE (abort, cnt<=0). s2=0 and cnt==STABLE_CYCLES-1 -> ZERO (cnt<=0). s2=0 otherwise -> stay, cnt<=cnt+1.
  - Unreachable or illegal encodings -> ZERO, cnt<=0.
- Latency:
  - Let edge 0 be the first edge that samples sw=1, with sw held from then on.
  - s2=1 after edge 1; FSM enters WAIT1 at edge 2.
  - db_level rises after edge STABLE_CYCLES+2 (edge 6 for the default of 4).
  - The falling direction is symmetric.
- Glitch rejection:
  - Any synchronised pulse shorter than STABLE_CYCLES clocks produces no db_level change. busy pulses only.
  - An abort always restarts qualification from cnt=0; bounce time is never accumulated.
- Counter:
  - Unsigned, CNT_W bits, never exceeds STABLE_CYCLES-1, so it cannot wrap.
  - The comparison is done at full CNT_W width.
- STABLE_CYCLES=1: the WAIT state is held for exactly one clock, giving a total latency of 3 edges.
- db_level changes at most once per qualification, so the downstream edge detector sees exactly one rising transition per accepted press.
- Reset release while sw=1: starts from ZERO and requires the full qualification. db_level=0 until edge STABLE_CYCLES+2 after release.

Test Plan:
- Clean press: release reset, 3 idle clocks, then hold sw=1 from edge 0 with STABLE_CYCLES=4 -> busy=1 after edges 2..5, db_level=1 after edge 6 and stays high. Downstream edge detector emits exactly one tick.
- Short glitch: sw=1 for 3 clocks then 0, STABLE_CYCLES=4 -> db_level stays 0 throughout; busy high for 3 clocks; FSM returns to ZERO.
- Bounce then settle: sw toggles 1,0,1,1,0,1 on consecutive clocks, then holds 1 -> db_level rises exactly STABLE_CYCLES+2 edges after the final 0->1 sample, with no earlier change.
- Release: from ONE, drive sw=0 with a 2-clock bounce back to 1, then hold 0 -> db_level stays 1 during the bounce and falls STABLE_CYCLES+2 edges after the final 1->0 sample.
- Reset mid-qualification: assert rst=0 between edges while in WAIT1 with cnt=2 -> db_level=0, busy=0 immediately (asynchronously). After release with sw held 1, db_level rises at edge STABLE_CYCLES+2.
- Boundary STABLE_CYCLES=1, CNT_W=1: sw held 1 -> db_level=1 after edge 3. A 1-clock pulse on sw reaches WAIT1 but aborts, db_level stays 0.
